decode_queue: RTL

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue_if.sv | 41 ++++
 rtl/decode_queue.sv | 125 ++++++++++++
 2 files changed

// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side signal bundle of the decode queue.
// The queue takes the slave view; fetch/issue (or a bench) take the master view.
interface decode_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            if_id_valid;
    logic [31:0]     if_id_instruc;
    logic [XLEN-1:0] if_id_pc;
    logic            id_if_ready;
    logic            flush;
    logic            id_iss_valid;
    logic            iss_id_ready;
    logic [6:0]      id_iss_opcode;
    logic [2:0]      id_iss_funct3;
    logic [6:0]      id_iss_funct7;
    logic [4:0]      id_iss_addra;
    logic [4:0]      id_iss_addrb;
    logic [4:0]      id_iss_regdest;
    logic [XLEN-1:0] id_iss_imedext;
    logic [XLEN-1:0] id_iss_pc;
    logic            id_iss_writereg;
    logic            id_iss_illegal;
    logic [CW-1:0]   id_count;

    modport slave (
        input  if_id_valid, if_id_instruc, if_id_pc, flush, iss_id_ready,
        output id_if_ready, id_iss_valid, id_iss_opcode, id_iss_funct3, id_iss_funct7,
               id_iss_addra, id_iss_addrb, id_iss_regdest, id_iss_imedext, id_iss_pc,
               id_iss_writereg, id_iss_illegal, id_count
    );

    modport master (
        output if_id_valid, if_id_instruc, if_id_pc, flush, iss_id_ready,
        input  id_if_ready, id_iss_valid, id_iss_opcode, id_iss_funct3, id_iss_funct7,
               id_iss_addra, id_iss_addrb, id_iss_regdest, id_iss_imedext, id_iss_pc,
               id_iss_writereg, id_iss_illegal, id_count
    );
endinterface

// File: rtl/decode_queue.sv
// RV32I decode queue: instructions are decoded on entry and held in a
// DEPTH-entry circular buffer; the head entry is presented to issue.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    decode_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            writereg;
        logic            illegal;
    } entry_t;

    // Width casts of signed slices perform the sign extension to XLEN.
    function automatic entry_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        entry_t e;
        e.opcode   = ins[6:0];
        e.rd       = ins[11:7];
        e.funct3   = ins[14:12];
        e.rs1      = ins[19:15];
        e.rs2      = ins[24:20];
        e.funct7   = ins[31:25];
        e.pc       = pc;
        e.imm      = '0;
        e.writereg = 1'b0;
        e.illegal  = 1'b0;
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                e.imm      = XLEN'($signed(ins[31:20]));
                e.writereg = (ins[11:7] != 5'd0);
            end
            7'b0100011: e.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
            7'b1100011: e.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            7'b0110111, 7'b0010111: begin
                e.imm      = XLEN'($signed({ins[31:12], 12'b0}));
                e.writereg = (ins[11:7] != 5'd0);
            end
            7'b1101111: begin
                e.imm      = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                e.writereg = (ins[11:7] != 5'd0);
            end
            7'b0110011: e.writereg = (ins[11:7] != 5'd0);
            default:    e.illegal  = 1'b1;
        endcase
        return e;
    endfunction

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_s, valid_s, enq_s, deq_s;
    entry_t        head_s, new_entry_s;

    assign ready_s     = (count_q < CW'(DEPTH));
    assign valid_s     = (count_q != '0);
    assign enq_s       = bus.if_id_valid && ready_s && !bus.flush;
    assign deq_s       = valid_s && bus.iss_id_ready && !bus.flush;
    assign new_entry_s = decode(bus.if_id_instruc, bus.if_id_pc);
    assign head_s      = mem_q[rd_ptr_q];

    // Next-state of pointers and occupancy; flush clears everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_s) wr_ptr_d = wr_ptr_q + AW'(1);
            else       wr_ptr_d = wr_ptr_q;
            if (deq_s) rd_ptr_d = rd_ptr_q + AW'(1);
            else       rd_ptr_d = rd_ptr_q;
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State and storage; entries are cleared on reset so the head reads zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (enq_s) mem_q[wr_ptr_q] <= new_entry_s;
        end
    end

    assign bus.id_if_ready     = ready_s;
    assign bus.id_iss_valid    = valid_s;
    assign bus.id_count        = count_q;
    assign bus.id_iss_opcode   = head_s.opcode;
    assign bus.id_iss_funct3   = head_s.funct3;
    assign bus.id_iss_funct7   = head_s.funct7;
    assign bus.id_iss_addra    = head_s.rs1;
    assign bus.id_iss_addrb    = head_s.rs2;
    assign bus.id_iss_regdest  = head_s.rd;
    assign bus.id_iss_imedext  = head_s.imm;
    assign bus.id_iss_pc       = head_s.pc;
    assign bus.id_iss_writereg = head_s.writereg;
    assign bus.id_iss_illegal  = head_s.illegal;
endmodule
